guess_search_4b: RTL and testbench
==================================

# guess_search_4b

Sequential binary-search engine that drives a 4-bit probe value into an external magnitude comparator and steers on the comparator's `gt`/`eq`/`lt` answer. It locates the hidden operand on the comparator's A side in at most 5 probes. It reports the located value, a found flag and the probe count. It sits on the B side of `cmp_4b`: it supplies operand B and consumes the three result lines.

## Interface
Parameters:
- none; width fixed at 4 bits, probe budget fixed by search depth (max 5).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a search; sampled only in IDLE.
- `gt` in 1: comparator result, hidden A > `guess`.
- `eq` in 1: comparator result, hidden A == `guess`.
- `lt` in 1: comparator result, hidden A < `guess`.
- `guess` out 4: probe value driven to comparator B input.
- `busy` out 1: high in PROBE.
- `done` out 1: one-cycle pulse when a search ends.
- `found` out 1: last search ended on `eq`; held until next `start`.
- `result` out 4: value at which `eq` was seen; held until next `start`.
- `tries` out 3: probes consumed by current/last search.
- `err` out 1: non-one-hot comparator result seen (see Configuration).

## Operation
- Internal state: `lo`, `hi` 5-bit unsigned bounds; FSM states IDLE, PROBE, DONE.
- Reset: state IDLE; `guess`=0, `busy`=0, `done`=0, `found`=0, `result`=0, `tries`=0, `err`=0, `lo`=0, `hi`=15.
- IDLE + `start`: `lo`←0, `hi`←15, `guess`←7, `tries`←0, `found`←0, `result`←0, `err`←0; go to PROBE.
- IDLE without `start`: hold all outputs.
- PROBE, every cycle: sample `gt`/`eq`/`lt` against the registered `guess`; `tries`←`tries`+1.
  - `eq`: `result`←`guess`, `found`←1; go to DONE.
  - `gt`: `lo'`=`guess`+1, `hi'`=`hi`.
  - `lt`: `lo'`=`lo`, `hi'`=`guess`−1 in 5-bit arithmetic, so 0−1 wraps to 31. Treat as empty: any `hi'`≥16 or `lo'`>`hi'` is empty.
  - On `gt`/`lt` with a non-empty range: `lo`,`hi` update; `guess`←(`lo'`+`hi'`)>>1 using a 5-bit sum, low 4 bits; stay in PROBE.
  - Empty range: `found`=0; go to DONE (inconsistent comparator).
  - All three low: treated as non-one-hot.
- DONE: `done`=1 for exactly one cycle; go to IDLE. `guess` holds last probe.
- `start` in PROBE or DONE is ignored.
- `rst` in any state aborts to IDLE with reset values on the next edge; no `done`.

## Timing
- `start` sampled at edge 0 → `guess`=7, `busy`=1 after edge 0.
- Comparator assumed combinational; each probe costs exactly 1 cycle.
- `eq` on probe k → `done` high in cycle k+1 after `start` edge; `found`/`result`/`tries` valid from the same edge and held.
- Worst case: 5 probes, `done` 6 cycles after `start` edge.
- `busy` and `done` never high together.

## Configuration
- `CMP_CHECK_EN` defined:
  - In PROBE, any of `gt`/`eq`/`lt` not exactly one-hot sets `err`←1, `found`←0, counts the probe, and goes to DONE.
  - `err` is held until next `start`.
- Undefined:
  - `err` tied 0.
  - Priority decode `eq` > `gt` > `lt`.
  - All-low is treated as `lt`.

## Test plan
- Hidden A=7: `start` → guesses {7}; `done` at cycle 2; `found`=1, `result`=7, `tries`=1.
- Hidden A=15 → guesses 7,11,13,14,15; `found`=1, `result`=15, `tries`=5.
- Hidden A=0 → guesses 7,3,1,0; `found`=1, `result`=0, `tries`=4.
- Comparator forced `gt`=1 always → guesses 7,11,13,14,15, then `lo`=16 empty; `done`, `found`=0, `tries`=5.
- `gt`=`lt`=1 on first probe:
  - With `CMP_CHECK_EN`: `err`=1, `found`=0, `tries`=1.
  - Without: treated as `gt`; next guess 11.
- `rst` after 2 probes → next cycle IDLE, all outputs 0, no `done`. `start` during `busy` has no effect on the guess sequence.

Source files
------------

// File: rtl/guess_search_4b_if.sv
// guess_search_4b_if: start/status handshake plus comparator probe/answer lines of guess_search_4b.
interface guess_search_4b_if;
    logic start, gt, eq, lt, busy, done, found, err;
    logic [3:0] guess, result;
    logic [2:0] tries;
    modport master(input start, gt, eq, lt, output guess, busy, done, found, result, tries, err);
    modport slave(output start, gt, eq, lt, input guess, busy, done, found, result, tries, err);
endinterface

// File: rtl/guess_search_4b.sv
// guess_search_4b: binary search steering a 4-bit probe by an external comparator's gt/eq/lt answer.
// Optional macro CMP_CHECK_EN flags non-one-hot comparator answers on err and ends the search.
module guess_search_4b (
    input logic clk,
    input logic rst,
    guess_search_4b_if.master bus
);
    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
    state_t state, state_n;
    logic [4:0] lo, hi, lo_n, hi_n, lo_c, hi_c, sum;
    logic [3:0] guess, guess_n, result, result_n;
    logic [2:0] tries, tries_n;
    logic found, found_n, err, err_n, bad, empty, up;
`ifdef CMP_CHECK_EN
    assign bad = ~((bus.gt ^ bus.eq ^ bus.lt) & ~(bus.gt & bus.eq & bus.lt));
`else
    assign bad = 1'b0;
`endif
    // eq beats gt; everything else, including all-low, narrows downward
    assign up = bus.gt & ~bus.eq;
    assign lo_c = up ? {1'b0, guess} + 5'd1 : lo;
    assign hi_c = up ? hi : {1'b0, guess} - 5'd1;
    assign empty = hi_c[4] | (lo_c > hi_c);
    assign sum = lo_c + hi_c;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lo <= 5'd0;
            hi <= 5'd15;
            guess <= 4'd0;
            result <= 4'd0;
            tries <= 3'd0;
            found <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            lo <= lo_n;
            hi <= hi_n;
            guess <= guess_n;
            result <= result_n;
            tries <= tries_n;
            found <= found_n;
            err <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        lo_n = lo;
        hi_n = hi;
        guess_n = guess;
        result_n = result;
        tries_n = tries;
        found_n = found;
        err_n = err;
        if (state == IDLE) begin
            if (bus.start) begin
                state_n = PROBE;
                lo_n = 5'd0;
                hi_n = 5'd15;
                guess_n = 4'd7;
                result_n = 4'd0;
                tries_n = 3'd0;
                found_n = 1'b0;
                err_n = 1'b0;
            end
        end else if (state == PROBE) begin
            tries_n = tries + 3'd1;
            if (bad) begin
                err_n = 1'b1;
                found_n = 1'b0;
                state_n = DONE;
            end else if (bus.eq) begin
                result_n = guess;
                found_n = 1'b1;
                state_n = DONE;
            end else if (empty) begin
                found_n = 1'b0;
                state_n = DONE;
            end else begin
                lo_n = lo_c;
                hi_n = hi_c;
                guess_n = sum[4:1];
            end
        end else begin
            state_n = IDLE;
        end
    end
    assign bus.guess = guess;
    assign bus.busy = state == PROBE;
    assign bus.done = state == DONE;
    assign bus.found = found;
    assign bus.result = result;
    assign bus.tries = tries;
    assign bus.err = err;
endmodule

// File: tb/tb_guess_search_4b.sv
// tb_guess_search_4b: plans each search as plain integer bisection, then checks guess_search_4b cycle by cycle.
// Build with CMP_CHECK_EN to match a DUT built with that macro.
module tb_guess_search_4b;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    guess_search_4b_if bif();
    guess_search_4b dut(.clk(clk), .rst(rst), .bus(bif));
`ifdef CMP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    int total = 0, bad = 0;
    logic [3:0] a = 4'd0;
    int mode = 0, k = 0, n = 0;
    logic [2:0] junk[8];
    logic [2:0] cmp_v;
    logic [3:0] eg[8];
    logic e_found, e_err;
    logic [3:0] e_result;
    logic [3:0] x_guess = 4'd0, x_result = 4'd0;
    logic [2:0] x_tries = 3'd0;
    logic x_busy = 1'b0, x_done = 1'b0, x_found = 1'b0, x_err = 1'b0;
    bit chk_on = 1'b0;

    // comparator environment: honest, stuck-gt, gt+lt on first probe, or random junk per probe
    always_comb begin
        cmp_v = {a > bif.guess, a == bif.guess, a < bif.guess};
        if (mode == 1) cmp_v = 3'b100;
        else if (mode == 2 && k == 0 && bif.guess == 4'd7) cmp_v = 3'b101;
        else if (mode == 3) cmp_v = junk[k[2:0]];
    end
    assign {bif.gt, bif.eq, bif.lt} = cmp_v;

    function automatic logic [2:0] ans(input logic [3:0] g, input int p);
        logic [2:0] c = {a > g, a == g, a < g};
        if (mode == 1) c = 3'b100;
        else if (mode == 2 && p == 0 && g == 4'd7) c = 3'b101;
        else if (mode == 3) c = junk[p[2:0]];
        return c;
    endfunction

    task automatic plan();
        int lo = 0, hi = 15, g = 7;
        bit fin = 1'b0;
        logic [2:0] c;
        n = 0; e_found = 1'b0; e_result = 4'd0; e_err = 1'b0;
        while (!fin && n < 8) begin
            c = ans(4'(g), n);
            eg[n] = 4'(g);
            n++;
            if (CHK && !(c == 3'b100 || c == 3'b010 || c == 3'b001)) begin
                e_err = 1'b1; fin = 1'b1;
            end else if (c[1]) begin
                e_found = 1'b1; e_result = 4'(g); fin = 1'b1;
            end else begin
                if (c[2]) lo = g + 1; else hi = g - 1;
                if (lo > hi) fin = 1'b1; else g = (lo + hi) / 2;
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        cmp("guess", 8'(bif.guess), 8'(x_guess));
        cmp("busy", 8'(bif.busy), 8'(x_busy));
        cmp("done", 8'(bif.done), 8'(x_done));
        cmp("found", 8'(bif.found), 8'(x_found));
        cmp("result", 8'(bif.result), 8'(x_result));
        cmp("tries", 8'(bif.tries), 8'(x_tries));
        cmp("err", 8'(bif.err), 8'(x_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_probe(input int j);
        k = j; x_guess = eg[j]; x_busy = 1'b1; x_done = 1'b0;
        x_found = 1'b0; x_result = 4'd0; x_tries = 3'(j); x_err = 1'b0;
    endtask

    task automatic run(input logic [3:0] av, input int md);
        a = av; mode = md;
        for (int i = 0; i < 8; i++) junk[i] = 3'($urandom);
        k = 0;
        plan();
        bif.start = 1'b1;
        for (int j = 0; j < n; j++) begin
            tick();
            set_probe(j);
            bif.start = 1'($urandom);
        end
        tick();
        bif.start = 1'b0;
        x_done = 1'b1; x_busy = 1'b0; x_found = e_found;
        x_result = e_result; x_tries = 3'(n); x_err = e_err;
        tick();
        x_done = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        bif.start = 1'b0;
        tick();
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        a = 4'd15; mode = 0; plan();
        cmp("pin15_n", 8'(n), 8'd5);
        cmp("pin15_g1", 8'(eg[1]), 8'd11);
        cmp("pin15_g4", 8'(eg[4]), 8'd15);
        cmp("pin15_res", 8'(e_result), 8'd15);
        a = 4'd0; plan();
        cmp("pin0_n", 8'(n), 8'd4);
        cmp("pin0_g2", 8'(eg[2]), 8'd1);
        cmp("pin0_found", 8'(e_found), 8'd1);
        a = 4'd7; plan();
        cmp("pin7_n", 8'(n), 8'd1);
        mode = 1; plan();
        cmp("pingt_n", 8'(n), 8'd5);
        cmp("pingt_found", 8'(e_found), 8'd0);
        a = 4'd3; mode = 2; plan();
        cmp("pin2_err", 8'(e_err), 8'(CHK));
        cmp("pin2_step", CHK ? 8'(n) : 8'(eg[1]), CHK ? 8'd1 : 8'd11);
        mode = 0;
        run(4'd7, 0);
        run(4'd15, 0);
        run(4'd0, 0);
        run(4'd9, 1);
        run(4'd3, 2);
        run(4'd12, 2);
        // abort after two probes: reset wins, no done
        a = 4'd15; mode = 0; k = 0; plan();
        bif.start = 1'b1;
        tick(); set_probe(0); bif.start = 1'b0;
        tick(); set_probe(1);
        tick(); set_probe(2); rst = 1'b1;
        tick();
        rst = 1'b0;
        x_guess = 4'd0; x_busy = 1'b0; x_done = 1'b0; x_found = 1'b0;
        x_result = 4'd0; x_tries = 3'd0; x_err = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            run(4'($urandom), r < 6 ? 0 : r - 6);
        end
        run(4'd15, 3);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
